// File: rtl/mcse_ipid_collector.sv
// mcse_ipid_collector
// Walks every IP index in turn, raises a trigger towards the GPIO host and
// receives a framed burst (header, payload words, trailer). Each good payload
// is packed MSB-first into one IP ID and written to the secure-boot IP ID
// register file. Bad or silent frames are retried a bounded number of times
// before the run is aborted with the failing IP index reported.
module mcse_ipid_collector #(
  parameter int                NUM_IPS      = 16,
  parameter int                WORDS_PER_IP = 16,
  parameter int                WORD_W       = 16,
  parameter int                ID_W         = 256,
  parameter logic [WORD_W-1:0] HDR          = 16'h7A7A,
  parameter logic [WORD_W-1:0] TRL          = 16'hB9B9,
  parameter int                TIMEOUT_CYC  = 1024,
  parameter int                MAX_RETRIES  = 3,
  localparam int               AW           = (NUM_IPS > 1) ? $clog2(NUM_IPS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              ip_trigger,
  output logic [AW-1:0]     ip_addr,
  input  logic              ip_valid,
  input  logic [WORD_W-1:0] ip_data,
  output logic              ipid_wr_en,
  output logic [AW-1:0]     ipid_wr_addr,
  output logic [ID_W-1:0]   ipid_wr_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [AW-1:0]     err_ip
);

  // Counter widths derived from the parameters.
  localparam int CW = (WORDS_PER_IP > 1) ? $clog2(WORDS_PER_IP) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  // Terminal counts, sized to their counters.
  localparam logic [AW-1:0] ADDR_LAST  = AW'(NUM_IPS - 1);
  localparam logic [CW-1:0] WORD_LAST  = CW'(WORDS_PER_IP - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);
  localparam logic [AW-1:0] ADDR_ONE   = AW'(1);
  localparam logic [CW-1:0] WORD_ONE   = CW'(1);
  localparam logic [TW-1:0] TMO_ONE    = TW'(1);
  localparam logic [RW-1:0] RETRY_ONE  = RW'(1);

  // FSM state encoding.
  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_TRIG  = 4'd1;
  localparam logic [3:0] ST_HDR   = 4'd2;
  localparam logic [3:0] ST_DATA  = 4'd3;
  localparam logic [3:0] ST_TRL   = 4'd4;
  localparam logic [3:0] ST_WR    = 4'd5;
  localparam logic [3:0] ST_REL   = 4'd6;
  localparam logic [3:0] ST_FIN   = 4'd7;
  localparam logic [3:0] ST_RETRY = 4'd8;
  localparam logic [3:0] ST_ERR   = 4'd9;

  // Registered state and outputs (_r) and their next values (_s).
  logic [3:0]      state_r,   state_s;
  logic [AW-1:0]   addr_r,    addr_s;
  logic [RW-1:0]   retry_r,   retry_s;
  logic [TW-1:0]   tmo_r,     tmo_s;
  logic [CW-1:0]   cnt_r,     cnt_s;
  logic [ID_W-1:0] shift_r,   shift_s;
  logic            trig_r,    trig_s;
  logic            wr_en_r,   wr_en_s;
  logic [AW-1:0]   wr_addr_r, wr_addr_s;
  logic [ID_W-1:0] wr_data_r, wr_data_s;
  logic            busy_r,    busy_s;
  logic            done_r,    done_s;
  logic            error_r,   error_s;
  logic [AW-1:0]   err_ip_r,  err_ip_s;

  // Append one payload word at the LSB end; after a full frame the first
  // received word ends up in the most significant slot.
  function automatic logic [ID_W-1:0] push_word(input logic [ID_W-1:0] acc,
                                                input logic [WORD_W-1:0] w);
    return {acc[ID_W-WORD_W-1:0], w};
  endfunction

  // A host word counts only when frame-valid is high and it matches exactly.
  function automatic logic word_is(input logic vld, input logic [WORD_W-1:0] w,
                                   input logic [WORD_W-1:0] ref_w);
    return vld && (w == ref_w);
  endfunction

  // Next-state and next-output logic for the collection sequencer.
  always_comb begin
    state_s   = state_r;
    addr_s    = addr_r;
    retry_s   = retry_r;
    tmo_s     = tmo_r;
    cnt_s     = cnt_r;
    shift_s   = shift_r;
    trig_s    = trig_r;
    wr_en_s   = 1'b0;
    wr_addr_s = wr_addr_r;
    wr_data_s = wr_data_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    error_s   = error_r;
    err_ip_s  = err_ip_r;

    case (state_r)
      ST_IDLE: begin
        trig_s = 1'b0;
        if (start) begin
          busy_s   = 1'b1;
          addr_s   = {AW{1'b0}};
          retry_s  = {RW{1'b0}};
          error_s  = 1'b0;
          err_ip_s = {AW{1'b0}};
          state_s  = ST_TRIG;
        end else begin
          state_s = ST_IDLE;
        end
      end

      // Never raise the trigger while the host still presents a frame.
      ST_TRIG: begin
        if (ip_valid) begin
          state_s = ST_TRIG;
        end else begin
          trig_s  = 1'b1;
          tmo_s   = {TW{1'b0}};
          state_s = ST_HDR;
        end
      end

      // Skip junk until the header; give up after the timeout window.
      ST_HDR: begin
        if (word_is(ip_valid, ip_data, HDR)) begin
          cnt_s   = {CW{1'b0}};
          shift_s = {ID_W{1'b0}};
          state_s = ST_DATA;
        end else if (tmo_r == TMO_LAST) begin
          trig_s  = 1'b0;
          state_s = ST_RETRY;
        end else begin
          tmo_s = tmo_r + TMO_ONE;
        end
      end

      // Payload must arrive back-to-back; a gap is a broken frame.
      ST_DATA: begin
        if (ip_valid) begin
          shift_s = push_word(shift_r, ip_data);
          if (cnt_r == WORD_LAST) begin
            state_s = ST_TRL;
          end else begin
            cnt_s = cnt_r + WORD_ONE;
          end
        end else begin
          trig_s  = 1'b0;
          state_s = ST_RETRY;
        end
      end

      // Trailer check; a good trailer launches the register-file write.
      ST_TRL: begin
        trig_s = 1'b0;
        if (word_is(ip_valid, ip_data, TRL)) begin
          wr_en_s   = 1'b1;
          wr_addr_s = addr_r;
          wr_data_s = shift_r;
          state_s   = ST_WR;
        end else begin
          state_s = ST_RETRY;
        end
      end

      ST_WR: begin
        state_s = ST_REL;
      end

      // Wait for the host to release the frame before moving on.
      ST_REL: begin
        if (!ip_valid) begin
          if (addr_r == ADDR_LAST) begin
            done_s  = 1'b1;
            busy_s  = 1'b0;
            state_s = ST_FIN;
          end else begin
            addr_s  = addr_r + ADDR_ONE;
            retry_s = {RW{1'b0}};
            state_s = ST_TRIG;
          end
        end else begin
          state_s = ST_REL;
        end
      end

      ST_FIN: begin
        state_s = ST_IDLE;
      end

      // Drop the partial ID and either re-request the same IP or abort.
      ST_RETRY: begin
        trig_s  = 1'b0;
        shift_s = {ID_W{1'b0}};
        if (!ip_valid) begin
          if (retry_r < RETRY_MAX) begin
            retry_s = retry_r + RETRY_ONE;
            state_s = ST_TRIG;
          end else begin
            error_s  = 1'b1;
            err_ip_s = addr_r;
            busy_s   = 1'b0;
            state_s  = ST_ERR;
          end
        end else begin
          state_s = ST_RETRY;
        end
      end

      ST_ERR: begin
        state_s = ST_IDLE;
      end

      default: begin
        trig_s  = 1'b0;
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      addr_r    <= {AW{1'b0}};
      retry_r   <= {RW{1'b0}};
      tmo_r     <= {TW{1'b0}};
      cnt_r     <= {CW{1'b0}};
      shift_r   <= {ID_W{1'b0}};
      trig_r    <= 1'b0;
      wr_en_r   <= 1'b0;
      wr_addr_r <= {AW{1'b0}};
      wr_data_r <= {ID_W{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      error_r   <= 1'b0;
      err_ip_r  <= {AW{1'b0}};
    end else begin
      state_r   <= state_s;
      addr_r    <= addr_s;
      retry_r   <= retry_s;
      tmo_r     <= tmo_s;
      cnt_r     <= cnt_s;
      shift_r   <= shift_s;
      trig_r    <= trig_s;
      wr_en_r   <= wr_en_s;
      wr_addr_r <= wr_addr_s;
      wr_data_r <= wr_data_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      error_r   <= error_s;
      err_ip_r  <= err_ip_s;
    end
  end

  assign ip_trigger   = trig_r;
  assign ip_addr      = addr_r;
  assign ipid_wr_en   = wr_en_r;
  assign ipid_wr_addr = wr_addr_r;
  assign ipid_wr_data = wr_data_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign error        = error_r;
  assign err_ip       = err_ip_r;

endmodule

// File: tb/tb_mcse_ipid_collector.sv
// Directed bench for mcse_ipid_collector: a host model answers triggers with
// framed bursts, a negedge monitor logs register-file writes and done pulses,
// and every comparison goes through chk().
module tb_mcse_ipid_collector;

  localparam logic [15:0]  HDR_W  = 16'h7A7A;
  localparam logic [15:0]  TRL_W  = 16'hB9B9;
  localparam logic [15:0]  JUNK_W = 16'h1234;
  localparam logic [255:0] IP0_ID =
    256'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000A_000B_000C_000D_000E_000F_0010;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         ip_valid = 1'b0;
  logic [15:0]  ip_data = 16'h0000;
  logic         ip_trigger;
  logic [3:0]   ip_addr;
  logic         ipid_wr_en;
  logic [3:0]   ipid_wr_addr;
  logic [255:0] ipid_wr_data;
  logic         busy;
  logic         done;
  logic         error;
  logic [3:0]   err_ip;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [3:0]   wr_addr_q[$];
  logic [255:0] wr_data_q[$];

  always #5 clk = ~clk;

  mcse_ipid_collector dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .ip_trigger   (ip_trigger),
    .ip_addr      (ip_addr),
    .ip_valid     (ip_valid),
    .ip_data      (ip_data),
    .ipid_wr_en   (ipid_wr_en),
    .ipid_wr_addr (ipid_wr_addr),
    .ipid_wr_data (ipid_wr_data),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .err_ip       (err_ip)
  );

  // Log every write strobe and done pulse, sampled away from the active edge.
  always @(negedge clk) begin
    if (ipid_wr_en) begin
      wr_addr_q.push_back(ipid_wr_addr);
      wr_data_q.push_back(ipid_wr_data);
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Payload word k of IP ip: IP index in the high byte, k+1 in the low byte.
  function automatic logic [15:0] word_of(input int ip, input int k);
    return 16'((ip << 8) | (k + 1));
  endfunction

  // Expected ID: word k occupies bits [255-16k -: 16].
  function automatic logic [255:0] exp_id(input int ip);
    logic [255:0] v;
    v = 256'h0;
    for (int k = 0; k < 16; k++) v[255-16*k -: 16] = word_of(ip, k);
    return v;
  endfunction

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_trig(input int budget);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!ip_trigger && n < budget);
    chk("trig_seen", 256'(ip_trigger), 256'(1));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (done_cnt == 0 && n < 60);
    repeat (3) @(negedge clk);
    chk("done_cnt", 256'(done_cnt), 256'(1));
    chk("busy_after_done", 256'(busy), 256'(0));
    chk("error_after_done", 256'(error), 256'(0));
  endtask

  task automatic wait_error();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!error && n < 60);
    chk("error_seen", 256'(error), 256'(1));
  endtask

  // Answer one trigger: optional junk, header, payload, given trailer, release.
  task automatic host_ip(input int ip, input int njunk, input logic [15:0] trl);
    wait_trig(2000);
    chk("trig_addr", 256'(ip_addr), 256'(ip));
    for (int j = 0; j < njunk; j++) begin
      @(posedge clk); #1 ip_valid = 1'b1; ip_data = JUNK_W;
    end
    @(posedge clk); #1 ip_valid = 1'b1; ip_data = HDR_W;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1 ip_data = word_of(ip, k);
    end
    @(posedge clk); #1 ip_data = trl;
    @(posedge clk); #1 ip_valid = 1'b0; ip_data = 16'h0000;
    @(negedge clk);
    chk("trig_drop", 256'(ip_trigger), 256'(0));
  endtask

  task automatic run_good(input int first, input int last);
    for (int ip = first; ip <= last; ip++) host_ip(ip, 0, TRL_W);
  endtask

  task automatic check_writes(input int n);
    chk("wr_count", 256'(wr_addr_q.size()), 256'(n));
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      chk("wr_addr", 256'(wr_addr_q[i]), 256'(i));
      chk("wr_data", wr_data_q[i], exp_id(i));
    end
  endtask

  task automatic chk_all_zero();
    chk("rst_trigger", 256'(ip_trigger), 256'(0));
    chk("rst_ip_addr", 256'(ip_addr), 256'(0));
    chk("rst_wr_en", 256'(ipid_wr_en), 256'(0));
    chk("rst_wr_addr", 256'(ipid_wr_addr), 256'(0));
    chk("rst_wr_data", ipid_wr_data, 256'h0);
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_error", 256'(error), 256'(0));
    chk("rst_err_ip", 256'(err_ip), 256'(0));
  endtask

  initial begin
    int hi;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero();
    @(posedge clk); #1 rst = 1'b0;

    // 1) Clean run over all 16 IPs.
    clear_log();
    pulse_start();
    @(negedge clk);
    chk("busy_on_start", 256'(busy), 256'(1));
    run_good(0, 15);
    wait_done();
    check_writes(16);
    if (wr_data_q.size() > 0) chk("ip0_literal", wr_data_q[0], IP0_ID);

    // 2) Bad trailer on IP3 retried, plus a start pulse ignored while busy.
    clear_log();
    pulse_start();
    host_ip(0, 0, TRL_W);
    pulse_start();
    run_good(1, 2);
    host_ip(3, 0, 16'hB9B8);
    repeat (2) @(negedge clk);
    chk("no_wr_bad_trl", 256'(wr_addr_q.size()), 256'(3));
    run_good(3, 15);
    wait_done();
    check_writes(16);

    // 3) IP5 fails four times: abort with err_ip=5.
    clear_log();
    pulse_start();
    run_good(0, 4);
    for (int a = 0; a < 4; a++) host_ip(5, 0, 16'h0000);
    wait_error();
    chk("err_ip_5", 256'(err_ip), 256'(5));
    chk("busy_after_err", 256'(busy), 256'(0));
    repeat (20) @(negedge clk);
    chk("no_done_err", 256'(done_cnt), 256'(0));
    chk("trig_idle_err", 256'(ip_trigger), 256'(0));
    chk("error_sticky", 256'(error), 256'(1));
    check_writes(5);

    // 4) Silent host: four timeouts of exactly 1024 trigger cycles each.
    clear_log();
    pulse_start();
    @(negedge clk);
    chk("error_cleared", 256'(error), 256'(0));
    chk("busy_restart", 256'(busy), 256'(1));
    for (int a = 0; a < 4; a++) begin
      wait_trig(100);
      chk("tmo_addr", 256'(ip_addr), 256'(0));
      hi = 1;
      while (ip_trigger && hi < 3000) begin
        @(negedge clk);
        if (ip_trigger) hi++;
      end
      chk("tmo_len", 256'(hi), 256'(1024));
    end
    wait_error();
    chk("err_ip_0", 256'(err_ip), 256'(0));
    chk("no_wr_tmo", 256'(wr_addr_q.size()), 256'(0));
    chk("no_done_tmo", 256'(done_cnt), 256'(0));

    // 5) Junk before the header on IP0, then good IPs up to 6.
    clear_log();
    pulse_start();
    host_ip(0, 3, TRL_W);
    run_good(1, 6);
    repeat (2) @(negedge clk);
    check_writes(7);

    // 6) Reset in the middle of IP7's payload, then a fresh run.
    wait_trig(100);
    chk("ip7_addr", 256'(ip_addr), 256'(7));
    @(posedge clk); #1 ip_valid = 1'b1; ip_data = HDR_W;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1 ip_data = word_of(7, k);
    end
    @(posedge clk); #1 rst = 1'b1; ip_valid = 1'b0; ip_data = 16'h0000;
    @(posedge clk);
    @(negedge clk);
    chk_all_zero();
    chk("no_wr_rst", 256'(wr_addr_q.size()), 256'(7));
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_after_rst", 256'(ip_trigger), 256'(0));
    clear_log();
    pulse_start();
    run_good(0, 15);
    wait_done();
    check_writes(16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
